// File: rtl/residue_check_seq_if.sv
// residue_check_seq_if: request/result bundle for residue_check_seq
// Parameters: W word width, M modulus, CW match-counter width
// Request side : start, in
// Result side  : busy, done, o, cnt, res (res only when RESIDUE_OUT_EN is defined)
interface residue_check_seq_if #(
    parameter int W  = 5,
    parameter int M  = 4,
    parameter int CW = 8
);
    logic          start;
    logic [W-1:0]  in;
    logic          busy;
    logic          done;
    logic          o;
    logic [CW-1:0] cnt;
`ifdef RESIDUE_OUT_EN
    localparam int RW = $clog2(M);
    logic [RW-1:0] res;
    modport master (output start, in, input busy, done, o, cnt, res);
    modport slave  (input start, in, output busy, done, o, cnt, res);
`else
    modport master (output start, in, input busy, done, o, cnt);
    modport slave  (input start, in, output busy, done, o, cnt);
`endif
endinterface

// File: rtl/residue_check_seq.sv
// residue_check_seq: serial MSB-first residue of a W-bit word modulo M, flags residue == R
// Ports: clk, rst_b (async active-low), bus (residue_check_seq_if.slave:
//   start/in request, busy/done status, o match flag, cnt saturating match count)
// Optional macro RESIDUE_OUT_EN adds bus.res carrying the final residue.
// Result outputs are loaded on the edge that enters DONE, so they are valid while done is high.
module residue_check_seq #(
    parameter int W  = 5,
    parameter int M  = 4,
    parameter int R  = 1,
    parameter int CW = 8
) (
    input logic                clk,
    input logic                rst_b,
    residue_check_seq_if.slave bus
);
    localparam int RW = $clog2(M);
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [RW:0]   MV   = (RW + 1)'(M);
    localparam logic [BW-1:0] LAST = BW'(W - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state, nxt;
    logic [W-1:0]  sr;
    logic [RW-1:0] res_q, res_nxt;
    logic [BW-1:0] bc;
    logic [RW:0]   t;
    logic          load, last, hit, o_q;
    logic [CW-1:0] cnt_q;
`ifdef RESIDUE_OUT_EN
    logic [RW-1:0] res_o;
    assign bus.res = res_o;
`endif
    // t < 2M always, so one conditional subtract keeps the residue reduced
    assign t       = {res_q, 1'b0} + (RW + 1)'(sr[W-1]);
    assign res_nxt = (t >= MV) ? RW'(t - MV) : RW'(t);
    assign hit     = res_nxt == RW'(R);
    assign last    = state == RUN && bc == LAST;
    assign load    = bus.start && state != RUN;
    assign bus.o   = o_q;
    assign bus.cnt = cnt_q;
    always_comb begin
        nxt      = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        nxt      = (state == RUN) ? (bc == LAST ? DONE : RUN) : (bus.start ? RUN : IDLE);
        bus.busy = state == RUN;
        bus.done = state == DONE;
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            sr    <= '0;
            res_q <= '0;
            bc    <= '0;
            o_q   <= 1'b0;
            cnt_q <= '0;
`ifdef RESIDUE_OUT_EN
            res_o <= '0;
`endif
        end else begin
            state <= nxt;
            if (load) begin
                sr    <= bus.in;
                res_q <= '0;
                bc    <= '0;
            end else if (state == RUN) begin
                sr    <= sr << 1;
                res_q <= res_nxt;
                bc    <= bc + 1'b1;
            end
            if (last) begin
                o_q <= hit;
                if (hit && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
`ifdef RESIDUE_OUT_EN
                res_o <= res_nxt;
`endif
            end
        end
    end
endmodule

// File: tb/tb_residue_check_seq.sv
// tb_residue_check_seq: table, directed and random checks of three residue_check_seq instances
module tb_residue_check_seq;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    residue_check_seq_if #(.W(5), .M(4), .CW(8)) b0 ();
    residue_check_seq_if #(.W(5), .M(4), .CW(3)) b1 ();
    residue_check_seq_if #(.W(5), .M(3), .CW(8)) b2 ();

    residue_check_seq #(.W(5), .M(4), .R(1), .CW(8)) u0 (.clk(clk), .rst_b(rst_b), .bus(b0));
    residue_check_seq #(.W(5), .M(4), .R(1), .CW(3)) u1 (.clk(clk), .rst_b(rst_b), .bus(b1));
    residue_check_seq #(.W(5), .M(3), .R(2), .CW(8)) u2 (.clk(clk), .rst_b(rst_b), .bus(b2));

    int passed = 0;
    int total = 0;
    int c0 = 0, c1 = 0, c2 = 0;
    int eo0 = 0, eo1 = 0, eo2 = 0;

    typedef struct {
        int v;
        int o0;
        int o2;
        int r0;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic s, input logic [4:0] v);
        b0.start = s; b1.start = s; b2.start = s;
        b0.in = v; b1.in = v; b2.in = v;
    endtask

    // reference: the residue is just v mod M; counters saturate at 2^CW-1
    task automatic model(input logic [4:0] v);
        int x;
        x = int'(v);
        eo0 = (x % 4 == 1) ? 1 : 0;
        eo1 = eo0;
        eo2 = (x % 3 == 2) ? 1 : 0;
        if (eo0 == 1 && c0 < 255) c0++;
        if (eo1 == 1 && c1 < 7) c1++;
        if (eo2 == 1 && c2 < 255) c2++;
    endtask

    task automatic check_outs(input logic [4:0] v);
        chk("o0", int'(b0.o), eo0);
        chk("cnt0", int'(b0.cnt), c0);
        chk("o1", int'(b1.o), eo1);
        chk("cnt1", int'(b1.cnt), c1);
        chk("o2", int'(b2.o), eo2);
        chk("cnt2", int'(b2.cnt), c2);
`ifdef RESIDUE_OUT_EN
        chk("res0", int'(b0.res), int'(v) % 4);
        chk("res2", int'(b2.res), int'(v) % 3);
`endif
    endtask

    // called at the negedge just before the accepting edge; returns at the done negedge
    task automatic wait_done(input logic s_run, input int prev_o);
        int n, nb;
        n = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (b0.busy) begin
                nb++;
                drive(s_run, 5'($urandom_range(0, 31)));
            end
            if (n == 1) chk("o_held", int'(b0.o), prev_o);
        end while (!b0.done && n < 20);
        chk("done_latency", n, 6);
        chk("busy_cycles", nb, 5);
        chk("done_sync", int'({b1.done, b2.done}), 3);
    endtask

    task automatic one_word(input logic [4:0] v);
        drive(1'b1, v);
        wait_done(1'b0, eo0);
        model(v);
        check_outs(v);
    endtask

    initial begin
        int n, extra, base;
        tbl = '{'{5, 1, 1, 1}, '{6, 0, 0, 2}, '{29, 1, 1, 1}, '{30, 0, 0, 2},
                '{9, 1, 0, 1}, '{0, 0, 0, 0}, '{31, 0, 0, 3}, '{17, 1, 1, 1}};
        drive(1'b0, 5'd0);
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(b0.busy), 0);
        chk("rst_done", int'(b0.done), 0);
        chk("rst_o", int'(b0.o), 0);
        chk("rst_cnt", int'(b0.cnt), 0);
        rst_b = 1'b1;
        @(negedge clk);

        one_word(5'd5);
        chk("first_o", int'(b0.o), 1);
        chk("first_cnt", int'(b0.cnt), 1);

        for (int i = 0; i < 8; i++) begin
            one_word(5'(tbl[i].v));
            chk("tbl_o0", int'(b0.o), tbl[i].o0);
            chk("tbl_o2", int'(b2.o), tbl[i].o2);
`ifdef RESIDUE_OUT_EN
            chk("tbl_res0", int'(b0.res), tbl[i].r0);
`endif
        end

        for (int i = 0; i < 40; i++) one_word(5'($urandom_range(0, 31)));

        base = c0;
        drive(1'b1, 5'd0);
        for (int i = 0; i < 32; i++) begin
            wait_done(1'b1, eo0);
            model(5'(i));
            check_outs(5'(i));
            if (i < 31) drive(1'b1, 5'(i + 1));
            else drive(1'b0, 5'd0);
        end
        chk("sweep_matches", int'(b0.cnt) - base, 8);

        drive(1'b1, 5'd5);
        @(negedge clk);
        drive(1'b0, 5'd5);
        @(negedge clk);
        drive(1'b1, 5'd3);
        @(negedge clk);
        drive(1'b0, 5'd3);
        n = 3;
        while (!b0.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrun_latency", n, 6);
        model(5'd5);
        check_outs(5'd5);
        chk("midrun_o", int'(b0.o), 1);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            extra += int'(b0.done);
        end
        chk("no_extra_done", extra, 0);

        drive(1'b1, 5'd5);
        @(negedge clk);
        drive(1'b0, 5'd5);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("mid_rst_busy", int'(b0.busy), 0);
        chk("mid_rst_done", int'(b0.done), 0);
        chk("mid_rst_o", int'(b0.o), 0);
        chk("mid_rst_cnt", int'(b0.cnt), 0);
        chk("mid_rst_cnt2", int'(b2.cnt), 0);
        @(negedge clk);
        rst_b = 1'b1;
        c0 = 0; c1 = 0; c2 = 0;
        eo0 = 0; eo1 = 0; eo2 = 0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            extra += int'(b0.done);
        end
        chk("rst_no_done", extra, 0);
        one_word(5'd9);
        chk("after_rst_o", int'(b0.o), 1);

        for (int i = 0; i < 10; i++) one_word(5'd1);
        chk("sat_cnt1", int'(b1.cnt), 7);
        chk("nosat_cnt0", int'(b0.cnt), 11);

        one_word(5'd29);
        chk("m3_29", int'(b2.o), 1);
        one_word(5'd30);
        chk("m3_30", int'(b2.o), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/residue_check_seq.md
Name: residue_check_seq

Overview:
- Sequential, parametrised successor to the combinational "in mod 4 == 1" detector.
- Accepts a W-bit word on a start strobe and computes its residue modulo M serially, MSB first, one bit per clock.
- Flags whether the residue equals a target R, and keeps a saturating count of matches.
- Sits in the lab datapath wherever a divisibility/residue check on sampled words is needed, without a wide combinational modulo.

Parameters:
- W, 5, input word width in bits (W >= 1)
- M, 4, modulus (M >= 2)
- R, 1, target residue (0 <= R < M)
- CW, 8, match-counter width in bits

Ports:
- clk  input  1  rising-edge clock
- rst_b  input  1  asynchronous active-low reset
- start  input  1  request to check word on in; sampled on rising clk
- in  input  W  word to check; sampled only when start is accepted
- busy  output  1  high while a word is being processed (state RUN)
- done  output  1  one-cycle pulse when result is valid
- o  output  1  match flag (residue == R); updated at done, held until next done
- cnt  output  CW  number of matches since reset; saturates at 2^CW-1

Behaviour:
- Reset (rst_b low, asynchronous):
  - state=IDLE; busy=0, done=0, o=0, cnt=0.
  - Internal shift register, residue and bit counter all cleared.
- Residue register width: RW = $clog2(M).
- Bit counter: counts 0..W-1.
- States:
  - IDLE: start=1 -> latch in into shift register, residue=0, bit counter=0, go to RUN. start=0 -> stay in IDLE.
  - RUN (busy=1):
    - Each cycle: b = shift-register MSB; t = 2*residue + b.
    - residue <= (t >= M) ? t-M : t. No divider or % operator; t needs RW+1 bits.
    - Shift register shifts left by 1; bit counter increments.
    - After the W-th bit is consumed, go to DONE.
  - DONE (one cycle):
    - done=1, busy=0.
    - o <= (final residue == R).
    - If match and cnt != all-ones, cnt <= cnt+1.
    - Next state: start=1 -> go straight to RUN with the new word (back-to-back allowed). start=0 -> IDLE.
- Latency:
  - start sampled at edge k -> RUN during cycles k+1..k+W -> done high in cycle k+W+1.
  - Back-to-back throughput: one word per W+1 cycles.
- start while in RUN is ignored; the in-flight word and in are unaffected.
- o holds its last value outside DONE and is not cleared at the start of a new word.
- Counter saturation: at 2^CW-1 further matches leave cnt unchanged; o and done still behave normally.
- Reset mid-RUN: immediate return to IDLE; the partial result is discarded; no done pulse.
- W=1: RUN lasts one cycle.
- Equivalence: the final residue must equal in mod M for every input value.

Optional Feature:
- Macro: RESIDUE_OUT_EN
- Defined:
  - Adds output port res [RW-1:0], carrying the final residue.
  - Loaded in the DONE cycle together with o; held until the next DONE; reset to 0.
- Undefined:
  - Port res is absent; all other behaviour is identical.

Test Plan:
- Defaults (W=5, M=4, R=1), in=5'b00101, start pulsed one cycle -> busy high 5 cycles; done pulse 6 cycles after the start edge; o=1; cnt=1.
- Defaults, in=6 -> o=0; cnt unchanged. With RESIDUE_OUT_EN, res=2.
- Defaults, sweep in=0..31 back-to-back with start held high -> done every 6 cycles; o=1 exactly for 1,5,9,...,29; final cnt=8.
- start re-asserted with in=3 mid-RUN of in=5 -> ignored; result o=1 (for 5); no extra done pulse.
- rst_b low for 1 cycle during RUN -> busy=0, done=0, o=0, cnt=0 immediately. A new start with in=9 afterwards completes normally with o=1.
- CW=3, 10 matching words (in=1 repeated) -> cnt stops at 7. Separate instance W=5, M=3, R=2: in=29 -> o=1 (29 mod 3 = 2); in=30 -> o=0.
